// File: rtl/hazard_ctrl_pkg.sv
// Opcode/funct constants and decode bundle for the hazard scheduler.
// Shared by the D-stage decoder and the stall/flush control.
package hazard_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0c;
    localparam logic [5:0] OP_ORI  = 6'h0d;
    localparam logic [5:0] OP_LUI  = 6'h0f;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;

    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_SLT   = 6'h2a;
    localparam logic [5:0] F_SLTU  = 6'h2b;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    typedef enum logic [1:0] {
        MD_NONE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2
    } md_kind_e;

    typedef struct packed {
        logic [4:0] a3;
        logic [1:0] tnew;
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
        md_kind_e   md;
        logic       md_use;
    } dec_t;

endpackage

// File: rtl/hazard_decode.sv
// D-stage decoder: destination register, Tnew, Tuse and mult/div class.
// Purely combinational; unknown encodings neither write nor read.
module hazard_decode
    import hazard_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] fuc,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    output dec_t       dec
);

    always_comb begin
        dec         = '0;
        dec.tuse_rs = TUSE_NONE;
        dec.tuse_rt = TUSE_NONE;
        dec.md      = MD_NONE;
        case (op)
            OP_R: begin
                case (fuc)
                    F_ADD, F_SUB, F_AND,
                    F_OR, F_SLT, F_SLTU: begin
                        dec.a3      = rd;
                        dec.tnew    = 2'd1;
                        dec.tuse_rs = 2'd1;
                        dec.tuse_rt = 2'd1;
                    end
                    F_MFHI, F_MFLO: begin
                        dec.a3     = rd;
                        dec.tnew   = 2'd1;
                        dec.md_use = 1'b1;
                    end
                    F_JR: dec.tuse_rs = 2'd0;
                    F_MULT, F_MULTU: begin
                        dec.tuse_rs = 2'd1;
                        dec.tuse_rt = 2'd1;
                        dec.md      = MD_MULT;
                        dec.md_use  = 1'b1;
                    end
                    F_DIV, F_DIVU: begin
                        dec.tuse_rs = 2'd1;
                        dec.tuse_rt = 2'd1;
                        dec.md      = MD_DIV;
                        dec.md_use  = 1'b1;
                    end
                    F_MTHI, F_MTLO: begin
                        dec.tuse_rs = 2'd1;
                        dec.md_use  = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ORI, OP_LUI, OP_ADDI, OP_ANDI: begin
                dec.a3      = rt;
                dec.tnew    = 2'd1;
                dec.tuse_rs = 2'd1;
            end
            OP_LW: begin
                dec.a3      = rt;
                dec.tnew    = 2'd2;
                dec.tuse_rs = 2'd1;
            end
            OP_SW: begin
                dec.tuse_rs = 2'd1;
                dec.tuse_rt = 2'd2;
            end
            OP_BEQ, OP_BNE: begin
                dec.tuse_rs = 2'd0;
                dec.tuse_rt = 2'd0;
            end
            OP_JAL: dec.a3 = 5'd31;
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush scheduler: shadow E/M (A3, Tnew) pipeline, data and
// HI/LO stalls, and the mult/div start pulse and busy counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] D_op,
    input  logic [5:0] D_fuc,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [4:0] D_rd,
    output logic       D_stall,
    output logic       PC_en,
    output logic       E_flush,
    output logic       md_start,
    output logic       md_busy
);

    dec_t       dec;
    logic [4:0] E_A3, M_A3;
    logic [1:0] E_Tnew, M_Tnew;
    md_kind_e   E_md;
    logic [3:0] cnt;
    logic       rs_hit, rt_hit, md_stall;

    hazard_decode u_dec (
        .op  (D_op),
        .fuc (D_fuc),
        .rt  (D_rt),
        .rd  (D_rd),
        .dec (dec)
    );

    always_comb begin
        rs_hit = (D_rs != 5'd0) &&
                 ((D_rs == E_A3 && dec.tuse_rs < E_Tnew) ||
                  (D_rs == M_A3 && dec.tuse_rs < M_Tnew));
        rt_hit = (D_rt != 5'd0) &&
                 ((D_rt == E_A3 && dec.tuse_rt < E_Tnew) ||
                  (D_rt == M_A3 && dec.tuse_rt < M_Tnew));
    end

    assign md_start = (E_md != MD_NONE);
    assign md_busy  = (cnt != 4'd0);
    assign md_stall = dec.md_use && (md_start || md_busy);
    assign D_stall  = rs_hit || rt_hit || md_stall;
    assign PC_en    = ~D_stall;
    assign E_flush  = D_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            E_A3   <= '0;
            E_Tnew <= '0;
            E_md   <= MD_NONE;
            M_A3   <= '0;
            M_Tnew <= '0;
            cnt    <= '0;
        end else begin
            E_A3   <= D_stall ? 5'd0 : dec.a3;
            E_Tnew <= D_stall ? 2'd0 : dec.tnew;
            E_md   <= D_stall ? MD_NONE : dec.md;
            M_A3   <= E_A3;
            M_Tnew <= (E_Tnew == 2'd0) ? 2'd0 : E_Tnew - 2'd1;
            if (md_start)
                cnt <= (E_md == MD_DIV) ? 4'(DIV_CYC)
                                        : 4'(MULT_CYC);
            else if (cnt != 4'd0)
                cnt <= cnt - 4'd1;
        end
    end

endmodule
